// File: rtl/rib_pkg.sv
// Shared RIB interconnect definitions: master ids, arbiter states and the
// slave address-nibble map that the bus mux decodes.
package rib_pkg;

    localparam int unsigned RIB_NUM_MASTERS  = 4;
    localparam int unsigned RIB_MID_W        = 2;
    localparam int unsigned RIB_BURST_CNT_W  = 8;

    typedef logic [RIB_MID_W-1:0] rib_mid_t;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } rib_arb_state_e;

    // Upper address nibble selecting each slave on the bus mux.
    localparam logic [3:0] RIB_SLV_ROM_NIB    = 4'h0;
    localparam logic [3:0] RIB_SLV_SRAM_NIB   = 4'h2;
    localparam logic [3:0] RIB_SLV_PERIPH_NIB = 4'h4;
    localparam logic [3:0] RIB_SLV_DDR_NIB    = 4'h8;

    function automatic logic [RIB_NUM_MASTERS-1:0] rib_mid_onehot(input rib_mid_t mid);
        return RIB_NUM_MASTERS'(1) << mid;
    endfunction

endpackage

// File: rtl/rib_rr_pick.sv
// Rotate-priority picker: first set request bit scanning from ptr upward, mod 4.
module rib_rr_pick
    import rib_pkg::*;
(
    input  logic [3:0] req,
    input  rib_mid_t   ptr,
    output rib_mid_t   idx,
    output logic       found
);

    logic [7:0] req_dbl;
    logic [3:0] req_rot;
    rib_mid_t   ofs;

    // Rotate so that bit 0 is the highest-priority requester.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr +: 4];

    always_comb begin
        ofs = '0;
        for (int i = 3; i >= 0; i--) begin
            if (req_rot[i]) begin
                ofs = 2'(i);
            end
        end
    end

    assign idx   = ptr + ofs;
    assign found = |req;

endmodule

// File: rtl/rib_arbiter.sv
// Round-robin bus arbiter for the four RIB masters with lock-aware,
// burst-limited ownership and registered grant outputs.
module rib_arbiter
    import rib_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = RIB_NUM_MASTERS,
    parameter int unsigned MAX_BURST   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [NUM_MASTERS-1:0] lock_i,
    output logic [1:0]             grant_o,
    output logic                   grant_valid_o,
    output logic [NUM_MASTERS-1:0] hold_flag_o,
    output logic                   busy_o
);

    localparam int unsigned CNT_W = RIB_BURST_CNT_W;
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] CNT_SAT    = '1;

    rib_arb_state_e   state_q,     state_d;
    rib_mid_t         owner_q,     owner_d;
    rib_mid_t         rr_ptr_q,    rr_ptr_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic [NUM_MASTERS-1:0] owner_oh;
    logic [NUM_MASTERS-1:0] others;
    logic [NUM_MASTERS-1:0] pick_req;
    rib_mid_t               pick_ptr;
    rib_mid_t               pick_idx;
    logic                   pick_found;
    rib_mid_t               owner_next;
    logic                   release_own;

    assign owner_oh   = rib_mid_onehot(owner_q);
    assign others     = req_i & ~owner_oh;
    assign owner_next = owner_q + 2'd1;

    // Lock only shields against burst pre-emption; dropping req always releases.
    assign release_own = !req_i[owner_q]
                       || (!lock_i[owner_q] && (others != '0) && (burst_cnt_q >= BURST_LAST));

    // One picker: fresh pick from rr_ptr when idle, handover pick over others when owned.
    always_comb begin
        pick_req = req_i;
        pick_ptr = rr_ptr_q;
        if (state_q == OWNED) begin
            pick_req = others;
            pick_ptr = owner_next;
        end
    end

    rib_rr_pick u_pick (
        .req   (pick_req),
        .ptr   (pick_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = OWNED;
                    owner_d     = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            OWNED: begin
                if (release_own) begin
                    rr_ptr_d = owner_next;
                    if (pick_found) begin
                        owner_d     = pick_idx;
                        burst_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if ((others != '0) && (burst_cnt_q != CNT_SAT)) begin
                    // A lone owner never accumulates burst time.
                    burst_cnt_d = burst_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_o       = owner_q;
    assign grant_valid_o = (state_q == OWNED);
    assign busy_o        = (state_q == OWNED);
    assign hold_flag_o   = req_i & ~(grant_valid_o ? owner_oh : '0);

endmodule

// File: tb/tb_rib_arbiter.sv
// Directed bench for rib_arbiter: reset, fairness, lock, lone master,
// simultaneous release with pointer wrap, and asynchronous reset.
module tb_rib_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req_i;
    logic [3:0] lock_i;

    logic [1:0] grant_o,  grant2_o;
    logic       gv_o,     gv2_o;
    logic [3:0] hold_o,   hold2_o;
    logic       busy_o,   busy2_o;

    int checks = 0;
    int errors = 0;

    rib_arbiter #(.NUM_MASTERS(4), .MAX_BURST(8)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req_i),
        .lock_i        (lock_i),
        .grant_o       (grant_o),
        .grant_valid_o (gv_o),
        .hold_flag_o   (hold_o),
        .busy_o        (busy_o)
    );

    rib_arbiter #(.NUM_MASTERS(4), .MAX_BURST(2)) u_dut2 (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req_i),
        .lock_i        (lock_i),
        .grant_o       (grant2_o),
        .grant_valid_o (gv2_o),
        .hold_flag_o   (hold2_o),
        .busy_o        (busy2_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_seq [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

        // Reset with a single requester
        rst    = 1'b0;
        req_i  = 4'b0100;
        lock_i = 4'b0000;
        tick();
        check("rst_hold", int'(hold_o), 4'b0100);
        check("rst_gv", int'(gv_o), 0);
        check("rst_grant", int'(grant_o), 0);
        check("rst_busy", int'(busy_o), 0);
        rst = 1'b1;
        tick();
        check("first_grant", int'(grant_o), 2);
        check("first_gv", int'(gv_o), 1);
        check("first_hold", int'(hold_o), 0);
        check("first_busy", int'(busy_o), 1);

        // Round-robin fairness with MAX_BURST = 2
        do_reset();
        req_i  = 4'b1111;
        lock_i = 4'b0000;
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("rr_grant%0d", i), int'(grant2_o), exp_seq[i]);
            check($sformatf("rr_gv%0d", i), int'(gv2_o), 1);
        end

        // Lock holds ownership past the burst limit
        do_reset();
        req_i  = 4'b0010;
        lock_i = 4'b0010;
        tick();
        check("lock_own", int'(grant_o), 1);
        req_i = 4'b1010;
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("lock_grant%0d", i), int'(grant_o), 1);
            check($sformatf("lock_hold%0d", i), int'(hold_o), 4'b1000);
        end
        check("lock_cnt", int'(u_dut.burst_cnt_q), 20);
        lock_i = 4'b0000;
        tick();
        check("unlock_grant", int'(grant_o), 3);
        check("unlock_gv", int'(gv_o), 1);
        check("unlock_hold", int'(hold_o), 4'b0010);
        check("unlock_cnt", int'(u_dut.burst_cnt_q), 0);
        check("unlock_ptr", int'(u_dut.rr_ptr_q), 2);

        // Lone master never times out
        do_reset();
        req_i  = 4'b0100;
        lock_i = 4'b0000;
        tick();
        for (int i = 0; i < 300; i++) begin
            tick();
            check("lone_grant", int'(grant_o), 2);
            check("lone_cnt", int'(u_dut.burst_cnt_q), 0);
        end
        req_i = 4'b0000;
        tick();
        check("lone_gv", int'(gv_o), 0);
        check("lone_busy", int'(busy_o), 0);
        check("lone_state", int'(u_dut.state_q), 0);
        check("lone_ptr", int'(u_dut.rr_ptr_q), 3);

        // Owner 3 drops req as masters 0 and 2 raise theirs
        do_reset();
        req_i = 4'b1000;
        tick();
        check("wrap_own", int'(grant_o), 3);
        req_i = 4'b0101;
        tick();
        check("wrap_grant", int'(grant_o), 0);
        check("wrap_gv", int'(gv_o), 1);
        check("wrap_ptr", int'(u_dut.rr_ptr_q), 0);
        check("wrap_hold", int'(hold_o), 4'b0100);

        // Asynchronous reset while master 1 owns
        do_reset();
        req_i = 4'b0011;
        tick();
        req_i = 4'b0010;
        tick();
        tick();
        check("ar_own", int'(grant_o), 1);
        check("ar_ptr_pre", int'(u_dut.rr_ptr_q), 1);
        #2 rst = 1'b0;
        #1;
        check("ar_gv", int'(gv_o), 0);
        check("ar_busy", int'(busy_o), 0);
        check("ar_ptr", int'(u_dut.rr_ptr_q), 0);
        check("ar_hold", int'(hold_o), 4'b0010);
        req_i = 4'b0011;
        #2 rst = 1'b1;
        tick();
        check("ar_grant", int'(grant_o), 0);
        check("ar_gv2", int'(gv_o), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
